// File: rtl/fc_seq_if.sv
// fc_seq_if: command/handshake bundle between the FC sequencer and fc_module.
// Signals:
//   command     3-bit phase command (0 NOP, 1 LOAD_F, 2 LOAD_B, 3 LOAD_W, 4 COMPUTE)
//   size        transfer/row count for the current command
//   cmd_valid   one-cycle pulse when command/size are first presented
//   f_writedone feature load complete pulse
//   b_writedone bias load complete pulse
//   w_writedone weight tile load complete pulse
//   c_done      tile compute complete pulse
interface fc_seq_if #(
    parameter int SIZE_W = 21
);
    logic [2:0]        command;
    logic [SIZE_W-1:0] size;
    logic              cmd_valid;
    logic              f_writedone;
    logic              b_writedone;
    logic              w_writedone;
    logic              c_done;

    modport master (
        output command, size, cmd_valid,
        input  f_writedone, b_writedone, w_writedone, c_done
    );

    modport slave (
        input  command, size, cmd_valid,
        output f_writedone, b_writedone, w_writedone, c_done
    );
endinterface

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: sequences feature load, bias load, then per-tile weight load and compute.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            one-cycle start pulse, accepted only in IDLE/DONE
//   in_len, out_len  feature count and output neuron count, latched on accepted start
//   abort            abort request, honoured only while busy
//   fc               command/size/cmd_valid out, writedone/compute-done pulses in
//   tile_idx         current tile index
//   busy, done       activity and completion levels
//   err              0 ok, 1 zero length/overflow, 2 timeout, 3 aborted
module fc_seq_ctrl #(
    parameter int TILE_ROWS = 16,
    parameter int SIZE_W    = 21,
    parameter int OUT_W     = 10,
    parameter int TIMEOUT   = 1048576
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [SIZE_W-1:0] in_len,
    input  logic [OUT_W-1:0]  out_len,
    input  logic              abort,
    fc_seq_if.master          fc,
    output logic [OUT_W-1:0]  tile_idx,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    localparam int TS = $clog2(TILE_ROWS);
    localparam int RW = TS + 1;
    localparam int XW = OUT_W + RW;
    localparam int PW = SIZE_W + RW;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [XW-1:0] TR = XW'(TILE_ROWS);

    typedef enum logic [3:0] {
        IDLE, ISSUE_F, WAIT_F, ISSUE_B, WAIT_B, ISSUE_W, WAIT_W, ISSUE_C, WAIT_C, NEXT, DONE
    } state_t;

    state_t            state, state_d;
    logic [SIZE_W-1:0] in_q, size_d;
    logic [OUT_W-1:0]  out_q, tile_d, nt;
    logic [1:0]        err_d;
    logic [2:0]        cmd_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [XW-1:0]     base, rem;
    logic [RW-1:0]     rows;
    logic [PW-1:0]     prod;
    logic              cv_d, load, zero, tmo, last, ovf, waiting;

    // Tile that the next LOAD_W/COMPUTE refers to: NEXT advances it, elsewhere it holds.
    assign nt      = (state == NEXT) ? tile_idx + OUT_W'(1) : tile_idx;
    assign base    = XW'(nt) << TS;
    assign rem     = XW'(out_q) - base;
    assign rows    = RW'((rem > TR) ? TR : rem);
    assign prod    = PW'(rows) * PW'(in_q);
    assign ovf     = |prod[PW-1:SIZE_W];
    assign last    = ((XW'(tile_idx) + XW'(1)) << TS) >= XW'(out_q);
    assign zero    = (in_len == '0) || (out_len == '0);
    assign waiting = state inside {WAIT_F, WAIT_B, WAIT_W, WAIT_C};
    // Timeout fires on the last cycle of a TIMEOUT-cycle wait; a pulse in that cycle wins.
    assign tmo     = cnt == CW'(TIMEOUT - 1);
    assign busy    = !(state inside {IDLE, DONE});
    assign done    = state == DONE;

    always_comb begin
        state_d = state;
        err_d   = err;
        tile_d  = tile_idx;
        load    = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                load    = 1'b1;
                tile_d  = '0;
                err_d   = zero ? 2'd1 : 2'd0;
                state_d = zero ? DONE : ISSUE_F;
            end
            ISSUE_F: state_d = WAIT_F;
            WAIT_F: if (fc.f_writedone) state_d = ISSUE_B;
                    else if (tmo) begin state_d = DONE; err_d = 2'd2; end
            ISSUE_B: state_d = WAIT_B;
            WAIT_B: if (fc.b_writedone) begin
                        state_d = ovf ? DONE : ISSUE_W;
                        err_d   = ovf ? 2'd1 : err;
                    end else if (tmo) begin state_d = DONE; err_d = 2'd2; end
            ISSUE_W: state_d = WAIT_W;
            WAIT_W: if (fc.w_writedone) state_d = ISSUE_C;
                    else if (tmo) begin state_d = DONE; err_d = 2'd2; end
            ISSUE_C: state_d = WAIT_C;
            WAIT_C: if (fc.c_done) state_d = NEXT;
                    else if (tmo) begin state_d = DONE; err_d = 2'd2; end
            NEXT: begin
                state_d = (last || ovf) ? DONE : ISSUE_W;
                err_d   = (!last && ovf) ? 2'd1 : 2'd0;
                tile_d  = last ? tile_idx : nt;
            end
            default: state_d = IDLE;
        endcase
        if (abort && busy) begin
            state_d = DONE;
            err_d   = 2'd3;
            tile_d  = tile_idx;
        end
        // Command/size are loaded on entry to an ISSUE state and held through its WAIT.
        cv_d   = state_d inside {ISSUE_F, ISSUE_B, ISSUE_W, ISSUE_C};
        cmd_d  = (state_d == ISSUE_F) ? 3'd1 :
                 (state_d == ISSUE_B) ? 3'd2 :
                 (state_d == ISSUE_W) ? 3'd3 :
                 (state_d == ISSUE_C) ? 3'd4 :
                 (state_d inside {IDLE, DONE}) ? 3'd0 : fc.command;
        size_d = (state_d == ISSUE_F) ? in_len :
                 (state_d == ISSUE_B) ? SIZE_W'(out_q) :
                 (state_d == ISSUE_W) ? prod[SIZE_W-1:0] :
                 (state_d == ISSUE_C) ? SIZE_W'(rows) :
                 (state_d inside {IDLE, DONE}) ? '0 : fc.size;
        cnt_d  = waiting ? cnt + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            in_q         <= '0;
            out_q        <= '0;
            tile_idx     <= '0;
            err          <= '0;
            cnt          <= '0;
            fc.command   <= '0;
            fc.size      <= '0;
            fc.cmd_valid <= 1'b0;
        end else begin
            state        <= state_d;
            in_q         <= load ? in_len : in_q;
            out_q        <= load ? out_len : out_q;
            tile_idx     <= tile_d;
            err          <= err_d;
            cnt          <= cnt_d;
            fc.command   <= cmd_d;
            fc.size      <= size_d;
            fc.cmd_valid <= cv_d;
        end
    end
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: directed self-checking bench for fc_seq_ctrl (TILE_ROWS=16, TIMEOUT=100).
module tb_fc_seq_ctrl;
    localparam int SIZE_W = 21;
    localparam int OUT_W  = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [SIZE_W-1:0] in_len = '0;
    logic [OUT_W-1:0]  out_len = '0;
    logic [OUT_W-1:0]  tile_idx;
    logic              busy, done;
    logic [1:0]        err;
    int                errors = 0;
    int                checks = 0;

    fc_seq_if #(.SIZE_W(SIZE_W)) fc();

    fc_seq_ctrl #(.TILE_ROWS(16), .SIZE_W(SIZE_W), .OUT_W(OUT_W), .TIMEOUT(100)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_len(in_len), .out_len(out_len),
        .abort(abort), .fc(fc), .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic exp_cmd(input string tag, input int c, input int s);
        chk({tag, "_cv"}, 32'(fc.cmd_valid), 1);
        chk({tag, "_cmd"}, 32'(fc.command), c);
        chk({tag, "_size"}, 32'(fc.size), s);
    endtask

    // One-cycle handshake pulse: 0 f_writedone, 1 b_writedone, 2 w_writedone, 3 c_done.
    task automatic hs(input int which);
        fc.f_writedone = (which == 0);
        fc.b_writedone = (which == 1);
        fc.w_writedone = (which == 2);
        fc.c_done      = (which == 3);
        step();
        fc.f_writedone = 1'b0;
        fc.b_writedone = 1'b0;
        fc.w_writedone = 1'b0;
        fc.c_done      = 1'b0;
    endtask

    task automatic go(input int il, input int ol);
        in_len  = SIZE_W'(il);
        out_len = OUT_W'(ol);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd"}, 32'(fc.command), 0);
        chk({tag, "_size"}, 32'(fc.size), 0);
        chk({tag, "_cv"}, 32'(fc.cmd_valid), 0);
        chk({tag, "_tile"}, 32'(tile_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic chk_done(input string tag, input int e, input int t);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), e);
        chk({tag, "_tile"}, 32'(tile_idx), t);
        chk({tag, "_cmd"}, 32'(fc.command), 0);
        chk({tag, "_cv"}, 32'(fc.cmd_valid), 0);
    endtask

    initial begin
        fc.f_writedone = 1'b0;
        fc.b_writedone = 1'b0;
        fc.w_writedone = 1'b0;
        fc.c_done      = 1'b0;
        repeat (2) step();
        chk_idle("reset");
        rstn = 1'b1;
        step();

        // Single tile: 256 features, 10 outputs
        go(256, 10);
        exp_cmd("t1_f", 1, 256);
        step();
        chk("t1_waitf_cv", 32'(fc.cmd_valid), 0);
        chk("t1_waitf_cmd", 32'(fc.command), 1);
        chk("t1_waitf_busy", 32'(busy), 1);
        hs(0);
        exp_cmd("t1_b", 2, 10);
        step();
        hs(1);
        exp_cmd("t1_w", 3, 2560);
        chk("t1_w_tile", 32'(tile_idx), 0);
        step();
        hs(2);
        exp_cmd("t1_c", 4, 10);
        step();
        hs(3);
        chk("t1_next_busy", 32'(busy), 1);
        chk("t1_next_cmd", 32'(fc.command), 4);
        step();
        chk_done("t1_end", 0, 0);
        chk("t1_end_size", 32'(fc.size), 0);

        // Three tiles: 128 features, 40 outputs -> rows 16,16,8
        go(128, 40);
        exp_cmd("t2_f", 1, 128);
        step();
        hs(0);
        exp_cmd("t2_b", 2, 40);
        step();
        hs(1);
        for (int t = 0; t < 3; t++) begin
            exp_cmd($sformatf("t2_w%0d", t), 3, (t < 2) ? 2048 : 1024);
            chk($sformatf("t2_tile%0d", t), 32'(tile_idx), t);
            step();
            hs(2);
            exp_cmd($sformatf("t2_c%0d", t), 4, (t < 2) ? 16 : 8);
            step();
            hs(3);
            step();
        end
        chk_done("t2_end", 0, 2);

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_done("abort_in_done", 0, 2);

        // Zero-length and overflow errors
        go(256, 0);
        chk_done("t3_out0", 1, 0);
        step();
        chk("t3_out0_cv_later", 32'(fc.cmd_valid), 0);
        go(0, 5);
        chk_done("t3_in0", 1, 0);
        go(131072, 16);
        exp_cmd("t3_ovf_f", 1, 131072);
        step();
        hs(0);
        exp_cmd("t3_ovf_b", 2, 16);
        step();
        hs(1);
        chk_done("t3_ovf", 1, 0);

        // Timeout in WAIT_W, then pulse exactly on the timeout cycle
        go(4, 4);
        exp_cmd("t4_f", 1, 4);
        step();
        hs(0);
        exp_cmd("t4_b", 2, 4);
        step();
        hs(1);
        exp_cmd("t4_w", 3, 16);
        step();
        repeat (99) step();
        chk("t4_pre_done", 32'(done), 0);
        chk("t4_pre_busy", 32'(busy), 1);
        step();
        chk_done("t4_tmo", 2, 0);
        go(4, 4);
        exp_cmd("t4b_f", 1, 4);
        step();
        hs(0);
        exp_cmd("t4b_b", 2, 4);
        step();
        hs(1);
        exp_cmd("t4b_w", 3, 16);
        step();
        repeat (99) step();
        hs(2);
        exp_cmd("t4b_c", 4, 4);
        step();
        hs(3);
        step();
        chk_done("t4b_end", 0, 0);

        // Abort in WAIT_C of tile 1, then a fresh full run
        go(8, 40);
        exp_cmd("t5_f", 1, 8);
        step();
        hs(0);
        exp_cmd("t5_b", 2, 40);
        step();
        hs(1);
        exp_cmd("t5_w0", 3, 128);
        step();
        hs(2);
        exp_cmd("t5_c0", 4, 16);
        step();
        hs(3);
        step();
        exp_cmd("t5_w1", 3, 128);
        chk("t5_tile1", 32'(tile_idx), 1);
        step();
        hs(2);
        exp_cmd("t5_c1", 4, 16);
        step();
        abort = 1'b1;
        fc.c_done = 1'b1;
        step();
        abort = 1'b0;
        fc.c_done = 1'b0;
        chk_done("t5_abort", 3, 1);
        go(8, 16);
        exp_cmd("t5r_f", 1, 8);
        chk("t5r_tile", 32'(tile_idx), 0);
        chk("t5r_err", 32'(err), 0);
        step();
        hs(0);
        exp_cmd("t5r_b", 2, 16);
        step();
        hs(1);
        exp_cmd("t5r_w", 3, 128);
        step();
        hs(2);
        exp_cmd("t5r_c", 4, 16);
        step();
        hs(3);
        step();
        chk_done("t5r_end", 0, 0);

        // Stray pulses, start while busy
        go(8, 16);
        exp_cmd("t6_f", 1, 8);
        fc.f_writedone = 1'b1;
        step();
        fc.f_writedone = 1'b0;
        chk("t6_issue_pulse_cv", 32'(fc.cmd_valid), 0);
        chk("t6_issue_pulse_cmd", 32'(fc.command), 1);
        step();
        chk("t6_still_waitf", 32'(fc.command), 1);
        hs(0);
        exp_cmd("t6_b", 2, 16);
        step();
        hs(1);
        exp_cmd("t6_w", 3, 128);
        step();
        fc.f_writedone = 1'b1;
        start = 1'b1;
        in_len = SIZE_W'(999);
        step();
        fc.f_writedone = 1'b0;
        start = 1'b0;
        chk("t6_stray_cv", 32'(fc.cmd_valid), 0);
        chk("t6_stray_cmd", 32'(fc.command), 3);
        chk("t6_stray_size", 32'(fc.size), 128);
        chk("t6_stray_busy", 32'(busy), 1);
        hs(2);
        exp_cmd("t6_c", 4, 16);
        step();
        hs(3);
        step();
        chk_done("t6_end", 0, 0);

        // Asynchronous reset in WAIT_B
        go(8, 16);
        exp_cmd("t7_f", 1, 8);
        step();
        hs(0);
        exp_cmd("t7_b", 2, 16);
        step();
        #2 rstn = 1'b0;
        #1;
        chk_idle("t7_async");
        @(negedge clk);
        rstn = 1'b1;
        step();
        step();
        chk_idle("t7_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
Sequencer for the fully-connected datapath. On a start pulse it issues the phase commands in order: feature load, bias load, then per-tile weight load and compute, until all output rows are done. Each command carries its transfer size. It sits between the APB register block (start, lengths, done/error status) and fc_module (command, size, writedone/compute-done handshakes). It replaces ad-hoc software sequencing of COMMAND/SIZE writes.

Parameters:
TILE_ROWS, 16, output rows computed per weight tile (power of two, 1..64)
SIZE_W, 21, width of size output and in_len
OUT_W, 10, width of out_len
TIMEOUT, 1048576, max cycles in any wait state before error

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse from APB block
in_len  in  SIZE_W  input feature count (words), sampled on accepted start
out_len  in  OUT_W  output neuron count, sampled on accepted start
abort  in  1  synchronous abort request
f_writedone  in  1  pulse: feature load complete
b_writedone  in  1  pulse: bias load complete
w_writedone  in  1  pulse: weight tile load complete
c_done  in  1  pulse: tile compute complete
command  out  3  0 NOP, 1 LOAD_F, 2 LOAD_B, 3 LOAD_W, 4 COMPUTE
size  out  SIZE_W  transfer/row count for current command
cmd_valid  out  1  one-cycle pulse when command/size first presented
tile_idx  out  OUT_W  index of current tile, from 0
busy  out  1  high in every state except IDLE and DONE
done  out  1  level, high in DONE
err  out  2  0 ok, 1 zero length, 2 timeout, 3 aborted; valid when done=1

Behaviour:
- Reset: state IDLE; command=0, size=0, cmd_valid=0, tile_idx=0, busy=0, done=0, err=0, all counters 0.
- States: IDLE, ISSUE_F, WAIT_F, ISSUE_B, WAIT_B, ISSUE_W, WAIT_W, ISSUE_C, WAIT_C, NEXT, DONE.
- Start is accepted in IDLE or DONE only; ignored while busy. Acceptance latches in_len/out_len, clears done/err and tile_idx, and goes to ISSUE_F. If either length is 0, it goes to DONE with err=1 instead.
- Latency: start in cycle N gives cmd_valid with LOAD_F in cycle N+1.
- ISSUE_x: one cycle; cmd_valid=1; command/size registered. Next state is the matching WAIT_x.
- command/size stay stable through WAIT_x and change only in the next ISSUE state. command is 0 and size is 0 in IDLE/DONE.
- Sizes: LOAD_F = in_len; LOAD_B = out_len; LOAD_W = rows*in_len truncated to SIZE_W; COMPUTE = rows.
- rows = min(TILE_ROWS, out_len - tile_idx*TILE_ROWS).
- If rows*in_len overflows SIZE_W, treat it as a zero-length error: go to DONE with err=1, checked at ISSUE_W.
- WAIT_F leaves on f_writedone to ISSUE_B. WAIT_B leaves on b_writedone to ISSUE_W. WAIT_W leaves on w_writedone to ISSUE_C. WAIT_C leaves on c_done to NEXT.
- Handshake pulses are honoured only in their own WAIT state. Pulses in an ISSUE cycle or any other state are ignored and not remembered.
- NEXT (1 cycle): if (tile_idx+1)*TILE_ROWS >= out_len, go to DONE with err=0. Otherwise tile_idx += 1 and go to ISSUE_W. Bias and features are not reloaded.
- Watchdog: counter clears on entry to each WAIT state and increments each cycle in it. On reaching TIMEOUT it goes to DONE with err=2. If the awaited pulse arrives in the same cycle as the timeout, the pulse wins.
- abort: in any busy state it goes to DONE with err=3 next cycle, taking precedence over handshake and timeout. abort in IDLE/DONE is ignored.
- start and abort asserted together while busy: abort wins, start ignored.
- DONE: done=1, busy=0; held until the next accepted start. tile_idx holds its last value.
- Reset mid-operation: immediate return to reset values; no command is re-issued.

Test Plan:
- in_len=256, out_len=10, TILE_ROWS=16, prompt handshakes -> cmd sequence (1,256),(2,10),(3,2560),(4,10); then done=1, err=0, tile_idx=0; first cmd_valid exactly 1 cycle after start.
- in_len=128, out_len=40 -> sizes LOAD_W 2048,2048,1024 and COMPUTE 16,16,8; tile_idx 0,1,2; exactly one LOAD_F and one LOAD_B.
- out_len=0 (or in_len=0) -> done=1, err=1 one cycle after start; no cmd_valid ever.
- TIMEOUT overridden to 100, w_writedone withheld -> done at 100 cycles after WAIT_W entry, err=2. Repeat with the pulse on the timeout cycle -> proceeds to ISSUE_C.
- abort in WAIT_C of tile 1 -> next cycle done=1, err=3, command=0. A new start then runs a full sequence from LOAD_F.
- Spurious f_writedone during WAIT_W, start pulse while busy, and rstn low in WAIT_B -> stray pulse and start ignored; reset drives all outputs to 0 asynchronously.
